cortex_m0_regfile: RTL and testbench

- Parametrised ARMv6-M register-file block: r0-r12, banked MSP/PSP, LR, PC, PRIMASK and CONTROL.
- Multiple read ports and two write ports, with a defined write-collision priority.
- Includes a register-list walker that sequences PUSH/POP/LDM/STM transfers one register per handshake.
- Sits between decode/execute and the load/store unit of the core.

---
 rtl/cortex_m0_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_cortex_m0_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cortex_m0_regfile.sv
// ARMv6-M register file: r0-r12, banked MSP/PSP, LR, PC, PRIMASK, CONTROL,
// two write ports with B-over-A priority, and a PUSH/POP/LDM/STM register-list walker.
module cortex_m0_regfile #(
  parameter int              BW        = 32,
  parameter int              NUM_RD    = 3,
  parameter int              BYPASS    = 1,
  parameter logic [BW-1:0]   RESET_SP  = '0,
  parameter logic [BW-1:0]   RESET_PC  = '0,
  parameter int              PC_RD_OFS = 4,
  parameter int              LIST_DESC = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*NUM_RD-1:0]   rd_addr,
  output logic [BW*NUM_RD-1:0]  rd_data,
  input  logic                  wa_en,
  input  logic [3:0]            wa_addr,
  input  logic [BW-1:0]         wa_data,
  input  logic                  wb_en,
  input  logic [3:0]            wb_addr,
  input  logic [BW-1:0]         wb_data,
  input  logic                  pc_next_en,
  input  logic [BW-1:0]         pc_next,
  output logic [BW-1:0]         pc,
  output logic [BW-1:0]         sp_active,
  input  logic                  handler_mode,
  input  logic                  control_we,
  input  logic [1:0]            control_wdata,
  output logic [1:0]            control,
  input  logic                  primask_we,
  input  logic                  primask_wdata,
  output logic                  primask,
  input  logic                  lst_start,
  input  logic [15:0]           lst_regs,
  output logic                  lst_valid,
  output logic [3:0]            lst_idx,
  input  logic                  lst_ready,
  output logic                  lst_busy,
  output logic [4:0]            lst_count,
  output logic                  lst_done
);

  localparam logic [BW-1:0] SP_MASK = {{(BW-2){1'b1}}, 2'b00};
  localparam logic [BW-1:0] PC_MASK = {{(BW-1){1'b1}}, 1'b0};
  localparam logic [BW-1:0] PC_OFS  = BW'(PC_RD_OFS);

  typedef enum logic {ST_IDLE = 1'b0, ST_WALK = 1'b1} lst_state_e;

  logic [BW-1:0] gpr_q [13];
  logic [BW-1:0] lr_q, msp_q, psp_q, pc_q;
  logic [1:0]    control_q;
  logic          primask_q;

  logic [15:0]   wr_hit_s;
  logic [BW-1:0] wr_val_s  [16];
  logic [BW-1:0] view_s    [16];
  logic [BW-1:0] byp_s     [16];
  logic [BW-1:0] sp_wval_s, pc_wval_s;
  logic          psp_sel_s;

  lst_state_e    state_q, state_d;
  logic [15:0]   mask_q, mask_d;
  logic [4:0]    count_q, count_d;
  logic          done_q, done_d;
  logic [3:0]    idx_s;

  function automatic logic [3:0] pick_idx(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    if (LIST_DESC != 0) begin
      for (int i = 0; i < 16; i++) if (m[i]) r = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, m[i]};
    return c;
  endfunction

  assign psp_sel_s = control_q[1] & ~handler_mode;
  assign sp_active = psp_sel_s ? psp_q : msp_q;
  assign pc        = pc_q;
  assign control   = control_q;
  assign primask   = primask_q;

  // Per-address winning write: port B overrides port A on a shared address
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      wr_hit_s[i] = (wa_en && (wa_addr == 4'(i))) || (wb_en && (wb_addr == 4'(i)));
      wr_val_s[i] = (wb_en && (wb_addr == 4'(i))) ? wb_data : wa_data;
    end
  end

  assign sp_wval_s = wr_val_s[13] & SP_MASK;
  assign pc_wval_s = wr_val_s[15] & PC_MASK;

  always_comb begin
    for (int i = 0; i < 13; i++) begin
      view_s[i] = gpr_q[i];
      byp_s[i]  = wr_val_s[i];
    end
    view_s[13] = sp_active;
    byp_s[13]  = sp_wval_s;
    view_s[14] = lr_q;
    byp_s[14]  = wr_val_s[14];
    view_s[15] = pc_q + PC_OFS;
    byp_s[15]  = pc_wval_s + PC_OFS;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if ((BYPASS != 0) && wr_hit_s[rd_addr[4*k +: 4]]) begin
        rd_data[BW*k +: BW] = byp_s[rd_addr[4*k +: 4]];
      end else begin
        rd_data[BW*k +: BW] = view_s[rd_addr[4*k +: 4]];
      end
    end
  end

  // Architectural state; SP write targets the bank selected before any CONTROL update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
      lr_q      <= '0;
      psp_q     <= '0;
      msp_q     <= RESET_SP & SP_MASK;
      pc_q      <= RESET_PC & PC_MASK;
      control_q <= 2'b00;
      primask_q <= 1'b0;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (wr_hit_s[i]) gpr_q[i] <= wr_val_s[i];
      end
      if (wr_hit_s[14]) lr_q <= wr_val_s[14];
      if (wr_hit_s[13]) begin
        if (psp_sel_s) psp_q <= sp_wval_s;
        else           msp_q <= sp_wval_s;
      end
      if (wr_hit_s[15])    pc_q <= pc_wval_s;
      else if (pc_next_en) pc_q <= pc_next & PC_MASK;
      if (control_we) control_q <= {(handler_mode ? control_q[1] : control_wdata[1]), control_wdata[0]};
      if (primask_we) primask_q <= primask_wdata;
    end
  end

  assign idx_s     = pick_idx(mask_q);
  assign lst_valid = (state_q == ST_WALK);
  assign lst_busy  = (state_q == ST_WALK);
  assign lst_idx   = idx_s;
  assign lst_count = count_q;
  assign lst_done  = done_q;

  // Walker next state; the remaining-bit mask shrinks by one bit per accepted index
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lst_start) begin
          if (lst_regs != 16'h0000) begin
            mask_d  = lst_regs;
            count_d = popcount16(lst_regs);
            state_d = ST_WALK;
          end else begin
            count_d = 5'd0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (lst_ready) begin
          mask_d = mask_q & ~(16'h0001 << idx_s);
          if ((mask_q & ~(16'h0001 << idx_s)) == 16'h0000) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WALK;
          end
        end else begin
          state_d = ST_WALK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = 16'h0000;
      end
    endcase
  end

  // Walker state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= 16'h0000;
      count_q <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cortex_m0_regfile.sv
// Randomised self-checking bench for cortex_m0_regfile against a sequential-write
// reference model; a second instance with descending list order checks walker ordering.
module tb_cortex_m0_regfile;
  localparam int BW = 32;
  localparam int NUM_RD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [4*NUM_RD-1:0]  rd_addr;
  logic [BW*NUM_RD-1:0] rd_data, d_rd_data;
  logic                 wa_en, wb_en, pc_next_en;
  logic [3:0]           wa_addr, wb_addr;
  logic [BW-1:0]        wa_data, wb_data, pc_next;
  logic [BW-1:0]        pc, sp_active, d_pc, d_sp_active;
  logic                 handler_mode, control_we, primask_we, primask_wdata;
  logic [1:0]           control_wdata, control, d_control;
  logic                 primask, d_primask;
  logic                 lst_start, lst_ready;
  logic [15:0]          lst_regs;
  logic                 lst_valid, lst_busy, lst_done, d_lst_valid, d_lst_busy, d_lst_done;
  logic [3:0]           lst_idx, d_lst_idx;
  logic [4:0]           lst_count, d_lst_count;

  cortex_m0_regfile #(.BW(BW), .NUM_RD(NUM_RD), .BYPASS(1), .RESET_SP(32'h2000_0FFF),
    .RESET_PC(32'h0000_00C1), .PC_RD_OFS(4), .LIST_DESC(0)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_next_en(pc_next_en), .pc_next(pc_next), .pc(pc), .sp_active(sp_active),
    .handler_mode(handler_mode), .control_we(control_we), .control_wdata(control_wdata),
    .control(control), .primask_we(primask_we), .primask_wdata(primask_wdata), .primask(primask),
    .lst_start(lst_start), .lst_regs(lst_regs), .lst_valid(lst_valid), .lst_idx(lst_idx),
    .lst_ready(lst_ready), .lst_busy(lst_busy), .lst_count(lst_count), .lst_done(lst_done));

  cortex_m0_regfile #(.BW(BW), .NUM_RD(NUM_RD), .BYPASS(1), .RESET_SP(32'h2000_0FFF),
    .RESET_PC(32'h0000_00C1), .PC_RD_OFS(4), .LIST_DESC(1)) dut_desc (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(d_rd_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_next_en(pc_next_en), .pc_next(pc_next), .pc(d_pc), .sp_active(d_sp_active),
    .handler_mode(handler_mode), .control_we(control_we), .control_wdata(control_wdata),
    .control(d_control), .primask_we(primask_we), .primask_wdata(primask_wdata), .primask(d_primask),
    .lst_start(lst_start), .lst_regs(lst_regs), .lst_valid(d_lst_valid), .lst_idx(d_lst_idx),
    .lst_ready(lst_ready), .lst_busy(d_lst_busy), .lst_count(d_lst_count), .lst_done(d_lst_done));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, writes applied in order A then B
  logic [31:0] m_r [16];
  logic [31:0] m_msp, m_psp, m_pc;
  logic [1:0]  m_ctrl;
  logic        m_pm;
  logic [31:0] n_r [16];
  logic [31:0] n_msp, n_psp, n_pc;
  logic [1:0]  n_ctrl;
  logic        n_pm;
  logic [15:0] wr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_msp = 32'h2000_0FFC; m_psp = 32'h0; m_pc = 32'h0000_00C0; m_ctrl = 2'b00; m_pm = 1'b0;
  endtask

  function automatic logic use_psp();
    return m_ctrl[1] && !handler_mode;
  endfunction

  task automatic apply(input logic [3:0] a, input logic [31:0] d);
    wr[a] = 1'b1;
    if (a == 4'd13) begin
      if (use_psp()) n_psp = d & ~32'd3;
      else           n_msp = d & ~32'd3;
    end else if (a == 4'd15) n_pc = d & ~32'd1;
    else n_r[a] = d;
  endtask

  task automatic compute_next();
    n_r = m_r; n_msp = m_msp; n_psp = m_psp; n_pc = m_pc; n_ctrl = m_ctrl; n_pm = m_pm;
    wr = 16'h0;
    if (pc_next_en) n_pc = pc_next & ~32'd1;
    if (wa_en) apply(wa_addr, wa_data);
    if (wb_en) apply(wb_addr, wb_data);
    if (control_we) begin
      n_ctrl[0] = control_wdata[0];
      if (!handler_mode) n_ctrl[1] = control_wdata[1];
    end
    if (primask_we) n_pm = primask_wdata;
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a == 4'd13) begin
      if (wr[13]) return use_psp() ? n_psp : n_msp;
      return use_psp() ? m_psp : m_msp;
    end
    if (a == 4'd15) return (wr[15] ? n_pc : m_pc) + 32'd4;
    return wr[a] ? n_r[a] : m_r[a];
  endfunction

  task automatic idle_inputs();
    wa_en = 1'b0; wb_en = 1'b0; pc_next_en = 1'b0; control_we = 1'b0; primask_we = 1'b0;
    lst_start = 1'b0; lst_ready = 1'b0;
  endtask

  // Called just after a negedge with inputs set: checks outputs, steps one edge, commits model
  task automatic run_cycle();
    logic [3:0] a;
    #1;
    compute_next();
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr[4*k +: 4];
      chk($sformatf("rd%0d_r%0d", k, a), rd_data[32*k +: 32], exp_read(a));
    end
    chk("sp_active", sp_active, use_psp() ? m_psp : m_msp);
    chk("pc", pc, m_pc);
    chk("control", {30'd0, control}, {30'd0, m_ctrl});
    chk("primask", {31'd0, primask}, {31'd0, m_pm});
    @(posedge clk);
    m_r = n_r; m_msp = n_msp; m_psp = n_psp; m_pc = n_pc; m_ctrl = n_ctrl; m_pm = n_pm;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic walk(input logic [15:0] m, input bit directed);
    logic [3:0] asc[$];
    logic [3:0] dsc[$];
    int cnt, n, dones;
    logic rdy;
    for (int i = 0; i < 16; i++) if (m[i]) asc.push_back(4'(i));
    for (int i = 15; i >= 0; i--) if (m[i]) dsc.push_back(4'(i));
    cnt = asc.size(); n = 0; dones = 0;
    lst_start = 1'b1; lst_regs = m; lst_ready = 1'b0;
    @(negedge clk);
    lst_start = 1'b0;
    chk("walk_count", {27'd0, lst_count}, cnt);
    chk("walk_count_desc", {27'd0, d_lst_count}, cnt);
    for (int cyc = 0; cyc < 64 && n < cnt; cyc++) begin
      rdy = directed ? (cyc != 1) : 1'($urandom_range(0, 1));
      lst_ready = rdy;
      lst_start = 1'($urandom_range(0, 1));
      lst_regs = 16'($urandom);
      #1;
      chk("walk_valid", {31'd0, lst_valid}, 32'd1);
      chk("walk_busy", {31'd0, d_lst_busy}, 32'd1);
      chk("walk_no_done", {31'd0, lst_done | d_lst_done}, 32'd0);
      if (rdy && lst_valid) begin
        chk($sformatf("walk_idx%0d", n), {28'd0, lst_idx}, {28'd0, asc[n]});
        chk($sformatf("walk_idx_desc%0d", n), {28'd0, d_lst_idx}, {28'd0, dsc[n]});
        n++;
      end
      @(negedge clk);
    end
    lst_start = 1'b0; lst_ready = 1'b0;
    chk("walk_all_accepted", n, cnt);
    #1;
    dones += int'(lst_done);
    chk("walk_done_pulse", {31'd0, lst_done}, 32'd1);
    chk("walk_done_desc", {31'd0, d_lst_done}, 32'd1);
    chk("walk_end_valid", {31'd0, lst_valid}, 32'd0);
    @(negedge clk);
    #1;
    dones += int'(lst_done);
    chk("walk_single_done", dones, 1);
    chk("walk_end_busy", {31'd0, lst_busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; rd_addr = '0; wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    pc_next = '0; handler_mode = 1'b0; control_wdata = 2'b00; primask_wdata = 1'b0;
    lst_regs = 16'h0;
    idle_inputs();
    do_reset();

    // Reset state
    rd_addr = {4'd13, 4'd14, 4'd15};
    #1;
    chk("rst_sp", sp_active, 32'h2000_0FFC);
    chk("rst_pc", pc, 32'h0000_00C0);
    chk("rst_ctrl", {30'd0, control}, 32'd0);
    chk("rst_r15", rd_data[31:0], 32'h0000_00C4);
    chk("rst_busy", {31'd0, lst_busy | lst_valid | lst_done}, 32'd0);
    run_cycle();

    // CONTROL/SP banking
    control_we = 1'b1; control_wdata = 2'b10;
    run_cycle(); idle_inputs();
    wa_en = 1'b1; wa_addr = 4'd13; wa_data = 32'h1000_0007; rd_addr = {4'd0, 4'd1, 4'd13};
    run_cycle(); idle_inputs();
    #1;
    chk("psp_written", rd_data[31:0], 32'h1000_0004);
    handler_mode = 1'b1;
    #1;
    chk("handler_msp", rd_data[31:0], 32'h2000_0FFC);
    control_we = 1'b1; control_wdata = 2'b01;
    run_cycle(); idle_inputs();
    chk("ctrl_handler", {30'd0, control}, 32'd3);
    handler_mode = 1'b0;

    // Write collision, port B wins and bypasses
    wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'hAAAA_AAAA;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h5555_5555; rd_addr = {4'd0, 4'd0, 4'd5};
    #1;
    chk("collide_bypass", rd_data[31:0], 32'h5555_5555);
    run_cycle(); idle_inputs();
    #1;
    chk("collide_stored", rd_data[31:0], 32'h5555_5555);

    // PC write beats pc_next
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h0000_0101; pc_next_en = 1'b1; pc_next = 32'h0000_0200;
    run_cycle(); idle_inputs();
    chk("pc_priority", pc, 32'h0000_0100);

    // Randomised register traffic
    for (int t = 0; t < 400; t++) begin
      wa_en = 1'($urandom_range(0, 1)); wb_en = 1'($urandom_range(0, 1));
      wa_addr = 4'($urandom); wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom);
      wa_data = $urandom; wb_data = $urandom;
      pc_next_en = 1'($urandom_range(0, 1)); pc_next = $urandom;
      handler_mode = ($urandom_range(0, 3) == 0);
      control_we = ($urandom_range(0, 5) == 0); control_wdata = 2'($urandom);
      primask_we = ($urandom_range(0, 5) == 0); primask_wdata = 1'($urandom);
      rd_addr = 12'($urandom);
      run_cycle();
    end
    idle_inputs();
    handler_mode = 1'b0;

    // Register-list walker
    walk(16'h80F1, 1'b1);
    walk(16'h0001, 1'b0);
    walk(16'hFFFF, 1'b0);
    for (int t = 0; t < 6; t++) walk(16'($urandom) | 16'h0100, 1'b0);

    // Reset aborts a walk after two accepts
    lst_start = 1'b1; lst_regs = 16'h80F1;
    @(negedge clk);
    lst_start = 1'b0; lst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lst_ready = 1'b0;
    do_reset();
    #1;
    chk("abort_busy", {31'd0, lst_busy}, 32'd0);
    chk("abort_valid", {31'd0, lst_valid}, 32'd0);
    chk("abort_done", {31'd0, lst_done}, 32'd0);
    chk("abort_count", {27'd0, lst_count}, 32'd0);
    @(negedge clk);
    #1;
    chk("abort_done_later", {31'd0, lst_done}, 32'd0);

    // Empty list
    @(negedge clk);
    lst_start = 1'b1; lst_regs = 16'h0000;
    @(negedge clk);
    lst_start = 1'b0;
    #1;
    chk("empty_done", {31'd0, lst_done}, 32'd1);
    chk("empty_busy", {31'd0, lst_busy}, 32'd0);
    chk("empty_count", {27'd0, lst_count}, 32'd0);
    @(negedge clk);
    #1;
    chk("empty_done_clear", {31'd0, lst_done}, 32'd0);
    chk("empty_busy_after", {31'd0, lst_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
